// File: rtl/sdram_arbiter_n_if.sv
// rtl/sdram_arbiter_n_if.sv - client/bridge bundle for the N-client SDRAM arbiter
interface sdram_arbiter_n_if #(
  parameter int N_CLIENTS = 6,
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 128
);
  localparam int GW = $clog2(N_CLIENTS);

  logic [N_CLIENTS-1:0]          cl_rd;
  logic [N_CLIENTS-1:0]          cl_wr;
  logic [N_CLIENTS*ADDR_W-1:0]   cl_addr;
  logic [N_CLIENTS*DATA_W-1:0]   cl_wrdata;
  logic [N_CLIENTS*DATA_W/8-1:0] cl_be;
  logic [N_CLIENTS-1:0]          cl_wait;
  logic [N_CLIENTS-1:0]          cl_ac;
  logic [N_CLIENTS-1:0]          cl_err;
  logic [DATA_W-1:0]             cl_rddata;
  logic [ADDR_W-1:0]             bridge_address;
  logic [DATA_W/8-1:0]           bridge_byte_enable;
  logic                          bridge_read;
  logic                          bridge_write;
  logic [DATA_W-1:0]             bridge_write_data;
  logic                          bridge_acknowledge;
  logic [DATA_W-1:0]             bridge_read_data;
  logic [GW-1:0]                 grant_id;

  modport slave (
    input  cl_rd, cl_wr, cl_addr, cl_wrdata, cl_be, bridge_acknowledge, bridge_read_data,
    output cl_wait, cl_ac, cl_err, cl_rddata, bridge_address, bridge_byte_enable,
           bridge_read, bridge_write, bridge_write_data, grant_id
  );

  modport master (
    output cl_rd, cl_wr, cl_addr, cl_wrdata, cl_be, bridge_acknowledge, bridge_read_data,
    input  cl_wait, cl_ac, cl_err, cl_rddata, bridge_address, bridge_byte_enable,
           bridge_read, bridge_write, bridge_write_data, grant_id
  );
endinterface

// File: rtl/sdram_arbiter_n.sv
// rtl/sdram_arbiter_n.sv - N-client SDRAM arbiter, fixed priority then round-robin
// Optional ISSUE watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter_n #(
  parameter int                   N_CLIENTS   = 6,
  parameter int                   ADDR_W      = 22,
  parameter int                   DATA_W      = 128,
  parameter logic [N_CLIENTS-1:0] PRIO_MASK   = '0,
  parameter int                   TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               reset,
  sdram_arbiter_n_if.slave  bus
);
  localparam int GW = $clog2(N_CLIENTS);
  localparam int BW = DATA_W / 8;

  if (N_CLIENTS < 2 || N_CLIENTS > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sdram_arbiter_n: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]       be_q, be_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rddata_q, rddata_d;

  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] ac;
  logic [GW-1:0]        win;
  logic                 found;
  logic                 timeout;

  assign req = bus.cl_rd | bus.cl_wr;

  // High-priority clients win by lowest index; otherwise rotate from the last grant.
  always_comb begin
    win   = grant_q;
    found = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found && req[i] && PRIO_MASK[i]) begin
        win   = GW'(i);
        found = 1'b1;
      end
    end
    for (int k = 1; k <= N_CLIENTS; k++) begin
      int idx;
      idx = (int'(grant_q) + k) % N_CLIENTS;
      if (!found && req[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    rddata_d = rddata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          addr_d  = bus.cl_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = bus.cl_wrdata[int'(win)*DATA_W +: DATA_W];
          be_d    = bus.cl_be[int'(win)*BW +: BW];
          // A combined rd+wr request is served as the write first.
          wr_d    = bus.cl_wr[win];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.bridge_acknowledge) begin
          rddata_d = bus.bridge_read_data;
          state_d  = S_DONE;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= GW'(N_CLIENTS - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      rddata_q <= rddata_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [TO_W-1:0]      to_cnt_q;
  logic [N_CLIENTS-1:0] err_q;

  // Counter sits at zero outside ISSUE, so it holds the number of ISSUE cycles already spent.
  assign timeout = (state_q == S_ISSUE) && !bus.bridge_acknowledge &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      to_cnt_q <= (state_q == S_ISSUE && !timeout) ? to_cnt_q + 1'b1 : '0;
      err_q    <= timeout ? ({{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_q) : '0;
    end
  end

  assign bus.cl_err = err_q;
`else
  assign timeout    = 1'b0;
  assign bus.cl_err = '0;
`endif

  always_comb begin
    ac = '0;
    if (state_q == S_DONE) ac[grant_q] = 1'b1;
  end

  assign bus.cl_ac              = ac;
  assign bus.cl_wait            = req & ~ac;
  assign bus.cl_rddata          = rddata_q;
  assign bus.bridge_address     = addr_q;
  assign bus.bridge_byte_enable = be_q;
  assign bus.bridge_write_data  = wdata_q;
  assign bus.bridge_read        = (state_q == S_ISSUE) && !wr_q;
  assign bus.bridge_write       = (state_q == S_ISSUE) && wr_q;
  assign bus.grant_id           = grant_q;
endmodule

// File: tb/tb_sdram_arbiter_n.sv
// tb/tb_sdram_arbiter_n.sv - directed self-checking bench for sdram_arbiter_n
module tb_sdram_arbiter_n;
  localparam int N  = 6;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_n_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) b0 ();
  sdram_arbiter_n_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bp ();

  logic          ack0 = 1'b0;
  logic          stray_ack = 1'b0;
  logic          ackp = 1'b0;
  int            ack_delay = 1;
  logic [DW-1:0] rdat0 = '0;

  assign b0.bridge_acknowledge = ack0 | stray_ack;
  assign b0.bridge_read_data   = rdat0;
  assign bp.bridge_acknowledge = ackp;
  assign bp.bridge_read_data   = '0;

  sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MASK(6'b000000), .TIMEOUT_CYC(8))
    dut (.clk(clk), .reset(reset), .bus(b0.slave));
  sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MASK(6'b100000), .TIMEOUT_CYC(8))
    dut_p (.clk(clk), .reset(reset), .bus(bp.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int            scnt0 = 0;
  int            both_hi = 0;
  int            ac0_q[$];
  logic [DW-1:0] rdv0_q[$];
  logic          cmdw0_q[$];
  logic [AW-1:0] cmda0_q[$];
  int            len0_q[$];
  int            err0_q[$];
  int            acp_q[$];

  // Bridge model + monitor for the round-robin instance; ack after ack_delay strobe cycles (0 = never).
  initial forever begin
    @(posedge clk); #1;
    if (b0.bridge_read && b0.bridge_write) both_hi++;
    if (b0.bridge_read || b0.bridge_write) begin
      scnt0++;
      if (scnt0 == 1) begin
        cmdw0_q.push_back(b0.bridge_write);
        cmda0_q.push_back(b0.bridge_address);
      end
    end else begin
      if (scnt0 != 0) len0_q.push_back(scnt0);
      scnt0 = 0;
    end
    ack0 = (ack_delay != 0) && (scnt0 == ack_delay);
    for (int i = 0; i < N; i++) begin
      if (b0.cl_ac[i]) begin
        ac0_q.push_back(i);
        rdv0_q.push_back(b0.cl_rddata);
      end
      if (b0.cl_err[i]) err0_q.push_back(i);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ackp = bp.bridge_read | bp.bridge_write;
    for (int i = 0; i < N; i++) if (bp.cl_ac[i]) acp_q.push_back(i);
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic clr_q;
    ac0_q.delete(); rdv0_q.delete(); cmdw0_q.delete(); cmda0_q.delete();
    len0_q.delete(); err0_q.delete(); acp_q.delete();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic wait_ac0(input int n, input int budget, input string tag);
    int c = 0;
    while (ac0_q.size() < n && c < budget) begin
      tick;
      c++;
    end
    chk({tag, "_ac_seen"}, 128'(ac0_q.size() >= n), 128'(1));
  endtask

  task automatic wait_strobe0(input int budget, input string tag);
    int c = 0;
    while (!(b0.bridge_read || b0.bridge_write) && c < budget) begin
      tick;
      c++;
    end
    chk({tag, "_strobe_seen"}, 128'(b0.bridge_read | b0.bridge_write), 128'(1));
  endtask

  localparam logic [DW-1:0] A5 = {16{8'hA5}};
  localparam logic [DW-1:0] WD = {4{32'hDEADBEEF}};

  initial begin
    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    int c;
    b0.cl_rd = '0; b0.cl_wr = '0; b0.cl_addr = '0; b0.cl_wrdata = '0; b0.cl_be = '0;
    bp.cl_rd = '0; bp.cl_wr = '0; bp.cl_addr = '0; bp.cl_wrdata = '0; bp.cl_be = '0;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;

    chk("rst_grant_id", 128'(b0.grant_id), 128'(5));
    chk("rst_bridge_read", 128'(b0.bridge_read), 128'(0));
    chk("rst_bridge_write", 128'(b0.bridge_write), 128'(0));
    chk("rst_cl_ac", 128'(b0.cl_ac), 128'(0));
    chk("rst_cl_err", 128'(b0.cl_err), 128'(0));
    chk("rst_cl_rddata", b0.cl_rddata, 128'(0));
    chk("rst_addr", 128'(b0.bridge_address), 128'(0));
    chk("rst_be", 128'(b0.bridge_byte_enable), 128'(0));
    chk("rst_wdata", b0.bridge_write_data, 128'(0));

    // Single read, bridge acks in the second strobe cycle.
    clr_q;
    ack_delay = 2;
    rdat0 = A5;
    b0.cl_addr[2*AW +: AW] = 22'h00123;
    b0.cl_rd[2] = 1'b1;
    #1;
    chk("rd1_wait_pending", 128'(b0.cl_wait), 128'(6'b000100));
    wait_ac0(1, 20, "rd1");
    chk("rd1_wait_in_ac", 128'(b0.cl_wait), 128'(0));
    b0.cl_rd[2] = 1'b0;
    tick;
    chk("rd1_rddata_hold", b0.cl_rddata, A5);
    tick; tick;
    chk("rd1_n_cmd", 128'(cmdw0_q.size()), 128'(1));
    chk("rd1_n_ac", 128'(ac0_q.size()), 128'(1));
    if (cmdw0_q.size() == 1 && ac0_q.size() == 1 && len0_q.size() >= 1) begin
      chk("rd1_is_read", 128'(cmdw0_q[0]), 128'(0));
      chk("rd1_addr", 128'(cmda0_q[0]), 128'(22'h00123));
      chk("rd1_strobe_len", 128'(len0_q[0]), 128'(2));
      chk("rd1_ac_client", 128'(ac0_q[0]), 128'(2));
      chk("rd1_rddata", rdv0_q[0], A5);
    end
    chk("rd1_grant_id", 128'(b0.grant_id), 128'(2));

    // Round-robin from reset among clients 0, 1, 3.
    do_reset;
    clr_q;
    ack_delay = 1;
    b0.cl_rd = 6'b001011;
    wait_ac0(6, 60, "rr");
    b0.cl_rd = '0;
    tick; tick;
    chk("rr_n_ac", 128'(ac0_q.size()), 128'(6));
    if (ac0_q.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), 128'(ac0_q[i]), 128'(rr_exp[i]));

    // Read and write together: write first, then a separate read.
    clr_q;
    b0.cl_addr[1*AW +: AW] = 22'h3ABCD;
    b0.cl_wrdata[1*DW +: DW] = WD;
    b0.cl_be[1*BW +: BW] = 16'hFFFF;
    b0.cl_rd[1] = 1'b1;
    b0.cl_wr[1] = 1'b1;
    wait_ac0(1, 20, "rw1");
    b0.cl_wr[1] = 1'b0;
    chk("rw_wdata", b0.bridge_write_data, WD);
    wait_ac0(2, 20, "rw2");
    b0.cl_rd[1] = 1'b0;
    tick; tick;
    chk("rw_n_cmd", 128'(cmdw0_q.size()), 128'(2));
    chk("rw_n_ac", 128'(ac0_q.size()), 128'(2));
    if (cmdw0_q.size() == 2) begin
      chk("rw_first_write", 128'(cmdw0_q[0]), 128'(1));
      chk("rw_second_read", 128'(cmdw0_q[1]), 128'(0));
    end
    chk("rw_be", 128'(b0.bridge_byte_enable), 128'(16'hFFFF));

    // Deassert after grant still completes; request dropped before grant never issues.
    clr_q;
    ack_delay = 4;
    b0.cl_addr[0 +: AW] = 22'h00010;
    b0.cl_rd[0] = 1'b1;
    wait_strobe0(10, "drop");
    b0.cl_rd[0] = 1'b0;
    b0.cl_rd[4] = 1'b1;
    tick;
    b0.cl_rd[4] = 1'b0;
    wait_ac0(1, 20, "drop");
    tick; tick; tick;
    chk("drop_n_cmd", 128'(cmdw0_q.size()), 128'(1));
    chk("drop_n_ac", 128'(ac0_q.size()), 128'(1));
    if (ac0_q.size() == 1 && len0_q.size() == 1) begin
      chk("drop_ac_client", 128'(ac0_q[0]), 128'(0));
      chk("drop_strobe_len", 128'(len0_q[0]), 128'(4));
    end

    // Acknowledge outside ISSUE is ignored.
    clr_q;
    rdat0 = 128'h1234;
    stray_ack = 1'b1;
    tick; tick;
    stray_ack = 1'b0;
    tick;
    chk("stray_n_ac", 128'(ac0_q.size()), 128'(0));
    chk("stray_n_cmd", 128'(cmdw0_q.size()), 128'(0));
    chk("stray_rddata_hold", b0.cl_rddata, A5);

    // Reset in the second ISSUE cycle aborts without cl_ac.
    clr_q;
    ack_delay = 0;
    b0.cl_rd[3] = 1'b1;
    wait_strobe0(10, "rst_mid");
    tick;
    chk("rst_mid_strobe_before", 128'(b0.bridge_read), 128'(1));
    reset = 1'b1;
    tick;
    chk("rst_mid_read_low", 128'(b0.bridge_read), 128'(0));
    chk("rst_mid_write_low", 128'(b0.bridge_write), 128'(0));
    chk("rst_mid_grant_id", 128'(b0.grant_id), 128'(5));
    b0.cl_rd[3] = 1'b0;
    reset = 1'b0;
    tick; tick; tick;
    chk("rst_mid_n_ac", 128'(ac0_q.size()), 128'(0));

    // Priority client 5 starves client 0 until it goes idle.
    clr_q;
    bp.cl_rd = 6'b100001;
    c = 0;
    while (acp_q.size() < 4 && c < 40) begin tick; c++; end
    bp.cl_rd[5] = 1'b0;
    c = 0;
    while (acp_q.size() < 5 && c < 40) begin tick; c++; end
    bp.cl_rd[0] = 1'b0;
    tick; tick;
    chk("prio_n_ac", 128'(acp_q.size()), 128'(5));
    if (acp_q.size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("prio_grant%0d", i), 128'(acp_q[i]), 128'(5));
      chk("prio_low_served", 128'(acp_q[4]), 128'(0));
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Bridge never acks: abort after 8 ISSUE cycles, then the next requester wins.
    clr_q;
    ack_delay = 0;
    b0.cl_rd = 6'b010100;
    c = 0;
    while (err0_q.size() < 1 && c < 40) begin tick; c++; end
    chk("to_err_seen", 128'(err0_q.size()), 128'(1));
    ack_delay = 1;
    b0.cl_rd[2] = 1'b0;
    wait_ac0(1, 20, "to_next");
    b0.cl_rd[4] = 1'b0;
    tick; tick; tick;
    chk("to_n_err", 128'(err0_q.size()), 128'(1));
    chk("to_n_ac", 128'(ac0_q.size()), 128'(1));
    chk("to_n_cmd", 128'(cmdw0_q.size()), 128'(2));
    if (err0_q.size() == 1 && ac0_q.size() == 1 && len0_q.size() >= 1) begin
      chk("to_err_client", 128'(err0_q[0]), 128'(2));
      chk("to_strobe_len", 128'(len0_q[0]), 128'(8));
      chk("to_next_client", 128'(ac0_q[0]), 128'(4));
    end
`else
    // Without the watchdog ISSUE waits indefinitely and cl_err stays low.
    clr_q;
    ack_delay = 0;
    b0.cl_rd[2] = 1'b1;
    repeat (14) tick;
    chk("nowd_still_issue", 128'(b0.bridge_read), 128'(1));
    chk("nowd_n_err", 128'(err0_q.size()), 128'(0));
    chk("nowd_n_ac", 128'(ac0_q.size()), 128'(0));
    reset = 1'b1;
    b0.cl_rd = '0;
    tick;
    reset = 1'b0;
    tick;
`endif

    chk("never_both_strobes", 128'(both_hi), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
